// File: rtl/call_stack.sv
// LIFO return-address stack with sticky overflow/underflow flags and a combinational top-of-stack read.
// Define CALL_STACK_WRAP_EN to let a push into a full stack overwrite the oldest entry instead of being dropped.
module call_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           writeData,
    output logic [WIDTH-1:0]           readData,
    input  logic                       clrErr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] topPtr;
    logic [PW-1:0] nextPtr;
    logic [PW-1:0] prevPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] cnt;
    logic          ovfFlag;
    logic          udfFlag;

    logic isEmpty;
    logic isFull;
    logic doPush;
    logic doPop;
    logic doReplace;
    logic doWrite;
    logic ovfEvt;
    logic udfEvt;

    assign isEmpty = (cnt == '0);
    assign isFull  = (cnt == FULL_CNT);

    // Pointer neighbours wrap explicitly so DEPTH need not be a power of two.
    always_comb begin
        nextPtr = (topPtr == LAST_PTR) ? '0 : topPtr + PW'(1);
        prevPtr = (topPtr == '0) ? LAST_PTR : topPtr - PW'(1);
    end

    always_comb begin
        doPush    = 1'b0;
        doPop     = 1'b0;
        doReplace = 1'b0;
        ovfEvt    = 1'b0;
        udfEvt    = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!isFull) begin
                    doPush = 1'b1;
                end else begin
                    ovfEvt = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                    doPush = 1'b1;
`endif
                end
            end
            2'b01: begin
                if (!isEmpty) begin
                    doPop = 1'b1;
                end else begin
                    udfEvt = 1'b1;
                end
            end
            2'b11: begin
                // Return-then-call: replace the top; on an empty stack only the call survives.
                if (!isEmpty) begin
                    doReplace = 1'b1;
                end else begin
                    doPush = 1'b1;
                    udfEvt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        doWrite = doPush | doReplace;
        wrPtr   = doReplace ? topPtr : nextPtr;
    end

    // Storage carries no reset; readData is gated by empty so stale entries never show.
    always_ff @(posedge clk) begin
        if (!rst && doWrite) begin
            mem[wrPtr] <= writeData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            topPtr  <= '0;
            cnt     <= '0;
            ovfFlag <= 1'b0;
            udfFlag <= 1'b0;
        end else begin
            if (doPush) begin
                topPtr <= nextPtr;
                if (!isFull) begin
                    cnt <= cnt + CW'(1);
                end
            end else if (doPop) begin
                topPtr <= prevPtr;
                cnt    <= cnt - CW'(1);
            end
            ovfFlag <= ovfEvt | (ovfFlag & ~clrErr);
            udfFlag <= udfEvt | (udfFlag & ~clrErr);
        end
    end

    assign readData  = isEmpty ? '0 : mem[topPtr];
    assign count     = cnt;
    assign full      = isFull;
    assign empty     = isEmpty;
    assign overflow  = ovfFlag;
    assign underflow = udfFlag;

endmodule

// File: tb/tb_call_stack.sv
// Randomized bench for call_stack (WIDTH=12, DEPTH=4) against a queue-based stack model,
// plus directed sequences with literal expectations.
module tb_call_stack;

    localparam int WIDTH = 12;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] writeData = '0;
    logic             clrErr = 1'b0;
    logic [WIDTH-1:0] readData;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    int tests = 0;
    int fails = 0;
    bit chkEn = 1'b0;

    call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .writeData(writeData),
        .readData(readData),
        .clrErr(clrErr),
        .count(count),
        .full(full),
        .empty(empty),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue whose back is the top of stack.
    logic [WIDTH-1:0] mq[$];
    bit mOvf = 1'b0;
    bit mUdf = 1'b0;
    bit ovE;
    bit unE;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mOvf = 1'b0;
            mUdf = 1'b0;
        end else begin
            ovE = 1'b0;
            unE = 1'b0;
            if (push && !pop) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(writeData);
                end else begin
                    ovE = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                    void'(mq.pop_front());
                    mq.push_back(writeData);
`endif
                end
            end else if (!push && pop) begin
                if (mq.size() > 0) void'(mq.pop_back());
                else unE = 1'b1;
            end else if (push && pop) begin
                if (mq.size() > 0) begin
                    mq[mq.size()-1] = writeData;
                end else begin
                    mq.push_back(writeData);
                    unE = 1'b1;
                end
            end
            mOvf = ovE | (mOvf & !clrErr);
            mUdf = unE | (mUdf & !clrErr);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) begin
            chk("readData", int'(readData), (mq.size() > 0) ? int'(mq[mq.size()-1]) : 0);
            chk("count", int'(count), mq.size());
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("empty", int'(empty), int'(mq.size() == 0));
            chk("overflow", int'(overflow), int'(mOvf));
            chk("underflow", int'(underflow), int'(mUdf));
        end
    end

    task automatic drive(input bit r, input bit pu, input bit po, input logic [WIDTH-1:0] d, input bit c);
        @(negedge clk);
        rst = r;
        push = pu;
        pop = po;
        writeData = d;
        clrErr = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic doReset();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle();
    endtask

    initial begin
        bit pu;
        bit po;
        int pushPct;
        int popPct;

        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chkEn = 1'b1;
        idle();
        chk("rst count", int'(count), 0);
        chk("rst empty", int'(empty), 1);
        chk("rst full", int'(full), 0);
        chk("rst readData", int'(readData), 0);

        // LIFO order
        drive(0, 1, 0, 12'h011, 0);
        drive(0, 1, 0, 12'h022, 0);
        drive(0, 1, 0, 12'h033, 0);
        idle();
        chk("lifo count", int'(count), 3);
        chk("lifo top", int'(readData), 'h033);
        drive(0, 0, 1, '0, 0);
        idle();
        chk("lifo pop1", int'(readData), 'h022);
        drive(0, 0, 1, '0, 0);
        idle();
        chk("lifo pop2", int'(readData), 'h011);
        drive(0, 0, 1, '0, 0);
        idle();
        chk("lifo pop3", int'(readData), 0);
        chk("lifo empty", int'(empty), 1);

        // Underflow and clear
        doReset();
        drive(0, 0, 1, '0, 0);
        idle();
        chk("udf set", int'(underflow), 1);
        chk("udf count", int'(count), 0);
        drive(0, 0, 0, '0, 1);
        idle();
        chk("udf clr", int'(underflow), 0);
        drive(0, 0, 1, '0, 1);
        idle();
        chk("udf wins clr", int'(underflow), 1);

        // Replace
        doReset();
        drive(0, 1, 0, 12'h0A0, 0);
        drive(0, 1, 1, 12'h0B0, 0);
        idle();
        chk("repl count", int'(count), 1);
        chk("repl top", int'(readData), 'h0B0);
        chk("repl no udf", int'(underflow), 0);
        drive(0, 0, 1, '0, 0);
        drive(0, 1, 1, 12'h0C0, 0);
        idle();
        chk("repl empty count", int'(count), 1);
        chk("repl empty top", int'(readData), 'h0C0);
        chk("repl empty udf", int'(underflow), 1);

        // Overflow
        doReset();
        for (int i = 1; i <= 5; i++) drive(0, 1, 0, WIDTH'(i), 0);
        idle();
        chk("ovf full", int'(full), 1);
        chk("ovf flag", int'(overflow), 1);
        chk("ovf count", int'(count), 4);
`ifdef CALL_STACK_WRAP_EN
        chk("ovf top", int'(readData), 5);
        for (int i = 4; i >= 2; i--) begin
            drive(0, 0, 1, '0, 0);
            idle();
            chk("wrap pop", int'(readData), i);
        end
`else
        chk("ovf top", int'(readData), 4);
        for (int i = 3; i >= 1; i--) begin
            drive(0, 0, 1, '0, 0);
            idle();
            chk("ovf pop", int'(readData), i);
        end
`endif
        drive(0, 0, 1, '0, 0);
        idle();
        chk("ovf last empty", int'(empty), 1);
        chk("ovf last rd", int'(readData), 0);

        // Reset mid-operation beats a concurrent push
        drive(0, 0, 1, '0, 0);
        drive(0, 1, 0, 12'h111, 0);
        drive(0, 1, 0, 12'h222, 0);
        drive(1, 1, 0, 12'h333, 0);
        idle();
        chk("midrst count", int'(count), 0);
        chk("midrst empty", int'(empty), 1);
        chk("midrst rd", int'(readData), 0);
        chk("midrst ovf", int'(overflow), 0);
        chk("midrst udf", int'(underflow), 0);

        // Randomized traffic with phases biased toward filling and draining
        for (int n = 0; n < 3000; n++) begin
            if (((n / 150) % 2) == 0) begin
                pushPct = 60;
                popPct = 35;
            end else begin
                pushPct = 30;
                popPct = 60;
            end
            pu = ($urandom_range(0, 99) < pushPct);
            po = ($urandom_range(0, 99) < popPct);
            drive(($urandom_range(0, 199) == 0), pu, po, WIDTH'($urandom), ($urandom_range(0, 15) == 0));
        end
        idle();
        idle();
        chkEn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
